// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcode, FSM state and iteration constants shared by the execute stage
package ula_pkg;

  localparam logic [2:0] OPC_ADD   = 3'b000;
  localparam logic [2:0] OPC_SUB   = 3'b001;
  localparam logic [2:0] OPC_AND   = 3'b010;
  localparam logic [2:0] OPC_OR    = 3'b011;
  localparam logic [2:0] OPC_XOR   = 3'b100;
  localparam logic [2:0] OPC_MUL   = 3'b101;
  localparam logic [2:0] OPC_DIV   = 3'b110;
  localparam logic [2:0] OPC_PASSA = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] ITER_CYCLES = 4'd8;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OPC_MUL) || (op == OPC_DIV);
  endfunction

endpackage

// File: rtl/ula_if.sv
// rtl/ula_if.sv - request/write-back bundle between the register-file side and the execute stage
interface ula_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] dest_address;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              flag_zero;
  logic              flag_carry;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;

  modport master (
    output start, opcode, dest_address, operand_a, operand_b,
    input  busy, done, result, flag_zero, flag_carry,
    input  write_enable, write_address, write_data
  );

  modport slave (
    input  start, opcode, dest_address, operand_a, operand_b,
    output busy, done, result, flag_zero, flag_carry,
    output write_enable, write_address, write_data
  );
endinterface

// File: rtl/ula_iter_unit.sv
// rtl/ula_iter_unit.sv - 8-step shift-add multiplier / restoring divider with its own step counter
module ula_iter_unit
  import ula_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] q,
  output logic              carry,
  output logic              last
);

  logic                r_active;
  logic                r_mode;
  logic [3:0]          r_count;
  logic [2*DATA_W-1:0] r_acc;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quo;

  logic [2*DATA_W-1:0] w_mul_acc;
  logic [DATA_W:0]     w_shift;
  logic                w_fits;
  logic [DATA_W-1:0]   w_sub;
  logic [DATA_W-1:0]   w_rem_nxt;
  logic [DATA_W-1:0]   w_quo_nxt;
  logic                w_div0;

  assign w_mul_acc = r_acc + (r_b[0] ? r_mcand : '0);

  // Restoring step: bring down the next dividend bit, subtract only if it fits.
  assign w_shift   = {r_rem, r_quo[DATA_W-1]};
  assign w_fits    = (w_shift >= {1'b0, r_b});
  assign w_sub     = w_shift[DATA_W-1:0] - r_b;
  assign w_rem_nxt = w_fits ? w_sub : w_shift[DATA_W-1:0];
  assign w_quo_nxt = {r_quo[DATA_W-2:0], w_fits};
  assign w_div0    = (r_b == '0);

  // q/carry present the value after the current step, so the final step is captured on the last edge.
  assign q     = r_mode ? (w_div0 ? '1 : w_quo_nxt) : w_mul_acc[DATA_W-1:0];
  assign carry = r_mode ? w_div0 : (|w_mul_acc[2*DATA_W-1:DATA_W]);
  assign last  = r_active && (r_count == ITER_CYCLES - 4'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_mode   <= 1'b0;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
    end else if (load) begin
      r_active <= 1'b1;
      r_mode   <= mode;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= {{DATA_W{1'b0}}, a};
      r_b      <= b;
      r_rem    <= '0;
      r_quo    <= a;
    end else if (r_active) begin
      if (r_mode) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end else begin
        r_acc   <= w_mul_acc;
        r_mcand <= r_mcand << 1;
        r_b     <= r_b >> 1;
      end
      if (last) begin
        r_active <= 1'b0;
        r_count  <= '0;
      end else begin
        r_count <= r_count + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ula_exec.sv
// rtl/ula_exec.sv - execute stage: request FSM, single-cycle ALU and register-file write-back
module ula_exec
  import ula_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic clock,
  input  logic reset,
  ula_if.slave ula
);

  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_carry;
  logic              r_we;
  logic              r_done;

  logic              w_accept;
  logic              w_load_iter;
  logic [DATA_W-1:0] w_iter_q;
  logic              w_iter_carry;
  logic              w_iter_last;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_dif;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_carry;
  logic [DATA_W-1:0] w_wb_res;
  logic              w_wb_carry;

  assign w_accept    = (r_state == S_IDLE) && ula.start;
  assign w_load_iter = w_accept && is_iter_op(ula.opcode);

  ula_iter_unit #(.DATA_W(DATA_W)) u_iter (
    .clock (clock),
    .reset (reset),
    .load  (w_load_iter),
    .mode  (ula.opcode == OPC_DIV),
    .a     (ula.operand_a),
    .b     (ula.operand_b),
    .q     (w_iter_q),
    .carry (w_iter_carry),
    .last  (w_iter_last)
  );

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif = {1'b0, r_a} - {1'b0, r_b};

  // MUL/DIV never reach EXEC, so their codes fall through to the default arm.
  always_comb begin
    w_alu_res   = r_a;
    w_alu_carry = 1'b0;
    case (r_op)
      OPC_ADD: begin
        w_alu_res   = w_sum[DATA_W-1:0];
        w_alu_carry = w_sum[DATA_W];
      end
      OPC_SUB: begin
        w_alu_res   = w_dif[DATA_W-1:0];
        w_alu_carry = w_dif[DATA_W];
      end
      OPC_AND: w_alu_res = r_a & r_b;
      OPC_OR:  w_alu_res = r_a | r_b;
      OPC_XOR: w_alu_res = r_a ^ r_b;
      default: w_alu_res = r_a;
    endcase
  end

  assign w_wb_res   = (r_state == S_ITER) ? w_iter_q     : w_alu_res;
  assign w_wb_carry = (r_state == S_ITER) ? w_iter_carry : w_alu_carry;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_dest   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_we   <= 1'b0;
          r_done <= 1'b0;
          if (w_accept) begin
            r_op    <= ula.opcode;
            r_dest  <= ula.dest_address;
            r_a     <= ula.operand_a;
            r_b     <= ula.operand_b;
            r_state <= is_iter_op(ula.opcode) ? S_ITER : S_EXEC;
          end
        end
        S_EXEC, S_ITER: begin
          if ((r_state == S_EXEC) || w_iter_last) begin
            r_result <= w_wb_res;
            r_carry  <= w_wb_carry;
            r_zero   <= (w_wb_res == '0);
            r_we     <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_WB;
          end
        end
        default: begin
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ula.busy          = (r_state != S_IDLE);
  assign ula.done          = r_done;
  assign ula.result        = r_result;
  assign ula.flag_zero     = r_zero;
  assign ula.flag_carry    = r_carry;
  assign ula.write_enable  = r_we;
  assign ula.write_address = r_dest;
  assign ula.write_data    = r_result;

endmodule
